nibble_serial_add_ctrl: RTL and testbench



---
 rtl/nibble_serial_add_ctrl.sv | 103 ++++++++++
 tb/tb_nibble_serial_add_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_add_ctrl.sv
// WIDTH-bit adder built from one external 4-bit ripple adder. The adder is used
// once per clock, LSB nibble first, and the carry is registered between steps.
module nibble_serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [3:0]       ra_a,
  output logic [3:0]       ra_b,
  output logic             ra_cin,
  input  logic [3:0]       ra_s,
  input  logic             ra_cout
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);

  // Handshake: a start seen in IDLE at a rising edge is accepted. busy is high
  // for the NIB nibble steps, then done pulses for exactly one cycle.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             carry;
  logic [IW-1:0]    idx;
  logic [3:0]       nib_a;
  logic [3:0]       nib_b;

  always_comb begin
    nib_a = 4'd0;
    nib_b = 4'd0;
    for (int i = 0; i < NIB; i++) begin
      if (idx == IW'(i)) begin
        nib_a = opa[4*i +: 4];
        nib_b = opb[4*i +: 4];
      end
    end
  end

  // The adder inputs are quiet outside RUN so the external adder sees zeros.
  assign ra_a   = (state == RUN) ? nib_a : 4'd0;
  assign ra_b   = (state == RUN) ? nib_b : 4'd0;
  assign ra_cin = (state == RUN) ? carry : 1'b0;

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      opa   <= '0;
      opb   <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            opa   <= a;
            opb   <= b;
            carry <= cin;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            state <= RUN;
          end
        end
        RUN: begin
          for (int i = 0; i < NIB; i++) begin
            if (idx == IW'(i)) sum[4*i +: 4] <= ra_s;
          end
          carry <= ra_cout;
          if (idx == LAST) begin
            cout  <= ra_cout;
            idx   <= '0;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Bench for nibble_serial_add_ctrl at WIDTH=16 and WIDTH=4, each wired to a
// behavioural 4-bit adder; results are compared against plain wide arithmetic.
module tb_nibble_serial_add_ctrl;

  localparam int W   = 16;
  localparam int NIB = W / 4;
  localparam int W4  = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- WIDTH=16 instance ----------------
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         busy, done;
  logic [W-1:0] sum;
  logic         cout;
  logic [3:0]   ra_a, ra_b, ra_s;
  logic         ra_cin, ra_cout;

  assign {ra_cout, ra_s} = 5'(ra_a) + 5'(ra_b) + 5'(ra_cin);

  nibble_serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout),
    .ra_a(ra_a), .ra_b(ra_b), .ra_cin(ra_cin), .ra_s(ra_s), .ra_cout(ra_cout)
  );

  // ---------------- WIDTH=4 instance ----------------
  logic          start4;
  logic [W4-1:0] a4, b4;
  logic          cin4;
  logic          busy4, done4;
  logic [W4-1:0] sum4;
  logic          cout4;
  logic [3:0]    ra_a4, ra_b4, ra_s4;
  logic          ra_cin4, ra_cout4;

  assign {ra_cout4, ra_s4} = 5'(ra_a4) + 5'(ra_b4) + 5'(ra_cin4);

  nibble_serial_add_ctrl #(.WIDTH(W4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4),
    .ra_a(ra_a4), .ra_b(ra_b4), .ra_cin(ra_cin4), .ra_s(ra_s4), .ra_cout(ra_cout4)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int passed = 0;
  logic [W:0]  exp_q[$];
  logic [W4:0] exp4_q[$];

  // Observations of one WIDTH=16 operation, indexed by cycle after acceptance.
  logic       obs_busy [0:NIB+1];
  logic       obs_done [0:NIB+1];
  logic [3:0] obs_ra_a [0:NIB-1];
  logic [3:0] obs_ra_b [0:NIB-1];
  logic       obs_ra_cin [0:NIB-1];
  logic [W-1:0] obs_sum;
  logic         obs_cout;

  // ---------------- reference model ----------------
  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c);
    return {1'b0, x} + {1'b0, y} + (W+1)'(c);
  endfunction

  function automatic logic [W4:0] ref_add4(input logic [W4-1:0] x, input logic [W4-1:0] y,
                                           input logic c);
    return {1'b0, x} + {1'b0, y} + (W4+1)'(c);
  endfunction

  // Carry entering nibble n = bit 4n of the sum of the low 4n bits plus cin.
  function automatic logic carry_into(input logic [W-1:0] x, input logic [W-1:0] y,
                                      input logic c, input int n);
    logic [W:0] m;
    logic [W:0] t;
    m = ((W+1)'(1) << (4 * n)) - (W+1)'(1);
    t = ({1'b0, x} & m) + ({1'b0, y} & m) + (W+1)'(c);
    return t[4*n];
  endfunction

  function automatic logic [3:0] nibble_of(input logic [W-1:0] x, input int n);
    return 4'(x >> (4 * n));
  endfunction

  // ---------------- driver tasks ----------------
  // Accept one operation and record NIB+2 cycles of outputs; inputs are
  // scrambled right after acceptance.
  task automatic do_op16(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    @(negedge clk);
    a = x; b = y; cin = c; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    for (int s = 0; s <= NIB + 1; s++) begin
      obs_busy[s] = busy;
      obs_done[s] = done;
      if (s < NIB) begin
        obs_ra_a[s]   = ra_a;
        obs_ra_b[s]   = ra_b;
        obs_ra_cin[s] = ra_cin;
      end
      if (s == NIB) begin
        obs_sum  = sum;
        obs_cout = cout;
      end
      if (s <= NIB) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    checks++;
    if ({busy, done, cout, ra_cin} !== 4'b0000) $display("FAIL reset_flags: busy=%b done=%b cout=%b ra_cin=%b, want all 0", busy, done, cout, ra_cin);
    else passed++;
    checks++;
    if (sum !== '0) $display("FAIL reset_sum: got %h want 0", sum);
    else passed++;
    checks++;
    if ({ra_a, ra_b} !== 8'h00) $display("FAIL reset_ra: ra_a=%h ra_b=%h want 0", ra_a, ra_b);
    else passed++;
    checks++;
    if ({busy4, done4, sum4, cout4} !== 7'd0) $display("FAIL reset_w4: busy=%b done=%b sum=%h cout=%b want 0", busy4, done4, sum4, cout4);
    else passed++;
  endtask

  task automatic test_basic;
    logic [W-1:0] x = 16'h1234;
    logic [W-1:0] y = 16'h4321;
    do_op16(x, y, 1'b0);
    for (int s = 0; s < NIB; s++) begin
      checks++;
      if ({obs_busy[s], obs_done[s]} !== 2'b10) $display("FAIL basic_run_flags[%0d]: busy=%b done=%b want 1 0", s, obs_busy[s], obs_done[s]);
      else passed++;
      checks++;
      if (obs_ra_a[s] !== nibble_of(x, s) || obs_ra_b[s] !== nibble_of(y, s)) $display("FAIL basic_ra[%0d]: ra_a=%h ra_b=%h want %h %h", s, obs_ra_a[s], obs_ra_b[s], nibble_of(x, s), nibble_of(y, s));
      else passed++;
    end
    checks++;
    if ({obs_busy[NIB], obs_done[NIB]} !== 2'b01) $display("FAIL basic_done_flags: busy=%b done=%b want 0 1", obs_busy[NIB], obs_done[NIB]);
    else passed++;
    checks++;
    if ({obs_busy[NIB+1], obs_done[NIB+1]} !== 2'b00) $display("FAIL basic_done_pulse: busy=%b done=%b want 0 0", obs_busy[NIB+1], obs_done[NIB+1]);
    else passed++;
    checks++;
    if ({obs_cout, obs_sum} !== 17'h05555) $display("FAIL basic_result: got %b_%h want 0_5555", obs_cout, obs_sum);
    else passed++;
  endtask

  task automatic test_ripple;
    logic [W-1:0] x = 16'hFFFF;
    logic [W-1:0] y = 16'h0001;
    do_op16(x, y, 1'b0);
    for (int s = 0; s < NIB; s++) begin
      checks++;
      if (obs_ra_cin[s] !== carry_into(x, y, 1'b0, s)) $display("FAIL ripple_cin[%0d]: got %b want %b", s, obs_ra_cin[s], carry_into(x, y, 1'b0, s));
      else passed++;
    end
    checks++;
    if ({obs_cout, obs_sum} !== ref_add(x, y, 1'b0)) $display("FAIL ripple_result: got %b_%h want %h", obs_cout, obs_sum, ref_add(x, y, 1'b0));
    else passed++;
  endtask

  task automatic test_corners;
    do_op16(16'hFFFF, 16'hFFFF, 1'b1);
    checks++;
    if ({obs_cout, obs_sum} !== 17'h1FFFF) $display("FAIL corner_all_ones: got %b_%h want 1_ffff", obs_cout, obs_sum);
    else passed++;
    do_op16(16'h0000, 16'h0000, 1'b1);
    checks++;
    if ({obs_cout, obs_sum} !== 17'h00001) $display("FAIL corner_cin_only: got %b_%h want 0_0001", obs_cout, obs_sum);
    else passed++;
  endtask

  // start held high: acceptance every 6 cycles, operands taken at acceptance.
  task automatic test_back_to_back;
    int n_done = 0;
    for (int e = 0; e < 30; e++) begin
      @(negedge clk);
      start = 1'b1;
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      if (e % 6 == 0) exp_q.push_back(ref_add(a, b, cin));
      @(posedge clk);
      #1;
      checks++;
      if (done !== (e % 6 == 4)) $display("FAIL b2b_done_timing[%0d]: got %b want %b", e, done, (e % 6 == 4));
      else passed++;
      if (done === 1'b1 && exp_q.size() > 0) begin
        logic [W:0] exp_v;
        exp_v = exp_q.pop_front();
        n_done++;
        checks++;
        if ({cout, sum} !== exp_v) $display("FAIL b2b_result[%0d]: got %b_%h want %h", e, cout, sum, exp_v);
        else passed++;
      end
    end
    start = 1'b0;
    checks++;
    if (n_done != 5 || exp_q.size() != 0) $display("FAIL b2b_count: got %0d results, %0d pending, want 5 and 0", n_done, exp_q.size());
    else passed++;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid;
    int extra_done = 0;
    @(negedge clk);
    a = 16'hABCD; b = 16'h1111; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({busy, sum} !== {1'b1, 16'h000E}) $display("FAIL mid_before_rst: busy=%b sum=%h want 1 000e", busy, sum);
    else passed++;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, cout, sum} !== 19'd0) $display("FAIL mid_rst_outputs: busy=%b done=%b cout=%b sum=%h want 0", busy, done, cout, sum);
    else passed++;
    checks++;
    if ({ra_a, ra_b, ra_cin} !== 9'd0) $display("FAIL mid_rst_ra: ra_a=%h ra_b=%h ra_cin=%b want 0", ra_a, ra_b, ra_cin);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || busy === 1'b1) extra_done++;
    end
    checks++;
    if (extra_done != 0) $display("FAIL mid_no_done: saw %0d active cycles after reset, want 0", extra_done);
    else passed++;
    do_op16(16'h0F0F, 16'hF0F1, 1'b1);
    checks++;
    if ({obs_cout, obs_sum} !== ref_add(16'h0F0F, 16'hF0F1, 1'b1)) $display("FAIL mid_fresh_result: got %b_%h want %h", obs_cout, obs_sum, ref_add(16'h0F0F, 16'hF0F1, 1'b1));
    else passed++;
  endtask

  task automatic test_random16;
    int errs = 0;
    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] x;
      logic [W-1:0] y;
      logic         c;
      logic [W:0]   exp_v;
      x = W'($urandom);
      y = W'($urandom);
      c = 1'($urandom_range(0, 1));
      exp_q.push_back(ref_add(x, y, c));
      do_op16(x, y, c);
      exp_v = exp_q.pop_front();
      checks++;
      if (obs_done[NIB] !== 1'b1 || {obs_cout, obs_sum} !== exp_v) begin
        errs++;
        if (errs <= 10) $display("FAIL rand16[%0d]: %h+%h+%b got done=%b %b_%h want %h", i, x, y, c, obs_done[NIB], obs_cout, obs_sum, exp_v);
      end else passed++;
    end
  endtask

  task automatic test_width4;
    int errs = 0;
    for (int i = 0; i < 1000; i++) begin
      logic [W4:0] exp_v;
      @(negedge clk);
      a4 = W4'($urandom); b4 = W4'($urandom); cin4 = 1'($urandom_range(0, 1));
      start4 = 1'b1;
      exp4_q.push_back(ref_add4(a4, b4, cin4));
      @(posedge clk);
      #1;
      start4 = 1'b0;
      a4 = W4'($urandom); b4 = W4'($urandom);
      checks++;
      if ({busy4, done4} !== 2'b10) begin
        errs++;
        if (errs <= 10) $display("FAIL w4_run[%0d]: busy=%b done=%b want 1 0", i, busy4, done4);
      end else passed++;
      @(posedge clk);
      #1;
      exp_v = exp4_q.pop_front();
      checks++;
      if ({busy4, done4} !== 2'b01 || {cout4, sum4} !== exp_v) begin
        errs++;
        if (errs <= 10) $display("FAIL w4_result[%0d]: busy=%b done=%b got %b_%h want %h", i, busy4, done4, cout4, sum4, exp_v);
      end else passed++;
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_basic();
    test_ripple();
    test_corners();
    test_back_to_back();
    test_reset_mid();
    test_random16();
    test_width4();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
